// File: rtl/serial_complement_seq.sv
// Bit-serial two's-complement negator: WIDTH-cycle latency from acceptance to out_valid.
// Backpressure: accepts a word only in IDLE; the result holds in DONE until out_ready.
module serial_complement_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_zero,
  output logic             out_ovf,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0]    LAST_CNT = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] src;
  logic [WIDTH-1:0] res;
  logic             seen_one;
  logic [CW-1:0]    cnt;
  logic             zero_f;
  logic             ovf_f;
  logic             accept;
  logic             o_bit;

  // Bits pass through up to and including the first 1; later bits are inverted.
  assign o_bit = seen_one ^ src[0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        accept   = in_valid;
        if (in_valid) begin
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        busy = 1'b1;
        if (cnt == LAST_CNT) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      src      <= '0;
      res      <= '0;
      seen_one <= 1'b0;
      cnt      <= '0;
      zero_f   <= 1'b0;
      ovf_f    <= 1'b0;
    end else if (accept) begin
      src      <= in_data;
      res      <= '0;
      seen_one <= 1'b0;
      cnt      <= '0;
      zero_f   <= (in_data == '0);
      ovf_f    <= (in_data == MOST_NEG);
    end else if (state == SHIFT) begin
      res      <= {o_bit, res[WIDTH-1:1]};
      src      <= src >> 1;
      seen_one <= seen_one | src[0];
      cnt      <= cnt + 1'b1;
    end
  end

  // Result flags are registered in every state; only out_valid qualifies them.
  assign out_data = res;
  assign out_zero = zero_f;
  assign out_ovf  = ovf_f;

endmodule

// File: tb/tb_serial_complement_seq.sv
// Directed bench for serial_complement_seq (WIDTH=8) with immediate-assertion checks.
module tb_serial_complement_seq;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_zero;
  logic       out_ovf;
  logic       busy;

  int n_assert = 0;
  int n_fail   = 0;

  serial_complement_seq #(.WIDTH(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_zero  (out_zero),
    .out_ovf   (out_ovf),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Accept d, wait for the result, optionally stall the consumer, then release.
  task automatic send(input string tag, input logic [7:0] d, input logic [7:0] ed,
                      input logic ez, input logic eo, input int hold, input bit noise);
    int lat;
    chk({tag, "_in_ready_idle"}, in_ready, 1);
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
    chk({tag, "_busy_after_accept"}, busy, 1);
    chk({tag, "_in_ready_shift"}, in_ready, 0);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 40) begin
      if (noise) begin
        in_valid = 1'($urandom_range(0, 1));
        in_data  = 8'($urandom);
      end
      tick();
      lat++;
    end
    chk({tag, "_latency"}, lat, 8);
    chk({tag, "_data"}, out_data, ed);
    chk({tag, "_zero"}, out_zero, ez);
    chk({tag, "_ovf"}, out_ovf, eo);
    for (int i = 0; i < hold; i++) begin
      if (noise) begin
        in_valid = 1'($urandom_range(0, 1));
        in_data  = 8'($urandom);
      end
      tick();
      chk({tag, "_hold_valid"}, out_valid, 1);
      chk({tag, "_hold_data"}, out_data, ed);
      chk({tag, "_hold_in_ready"}, in_ready, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_valid_after_release"}, out_valid, 0);
    chk({tag, "_in_ready_after_release"}, in_ready, 1);
  endtask

  initial begin
    logic [7:0] got [2];
    int acc_cyc [2];
    int xfer_cyc [2];
    int acc_cnt;
    int res_cnt;
    int cyc;
    int seen_valid;

    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out_data", out_data, 8'h00);
    chk("rst_out_zero", out_zero, 0);
    chk("rst_out_ovf", out_ovf, 0);

    send("w01", 8'h01, 8'hFF, 1'b0, 1'b0, 0, 1'b0);
    send("w00", 8'h00, 8'h00, 1'b1, 1'b0, 0, 1'b0);
    send("w80", 8'h80, 8'h80, 1'b0, 1'b1, 0, 1'b0);
    send("w36", 8'h36, 8'hCA, 1'b0, 1'b0, 5, 1'b0);

    // Back-to-back with in_valid and out_ready held high.
    in_valid  = 1'b1;
    in_data   = 8'h05;
    out_ready = 1'b1;
    acc_cnt   = 0;
    res_cnt   = 0;
    cyc       = 0;
    for (int i = 0; i < 60 && res_cnt < 2; i++) begin
      if (in_valid && in_ready && acc_cnt < 2) begin
        acc_cyc[acc_cnt] = cyc;
        acc_cnt++;
      end
      if (out_valid && out_ready) begin
        got[res_cnt]      = out_data;
        xfer_cyc[res_cnt] = cyc;
        res_cnt++;
      end
      tick();
      cyc++;
      if (acc_cnt == 1) in_data = 8'hFB;
      if (acc_cnt == 2) in_valid = 1'b0;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("b2b_results", res_cnt, 2);
    chk("b2b_accepts", acc_cnt, 2);
    chk("b2b_first", got[0], 8'hFB);
    chk("b2b_second", got[1], 8'h05);
    chk("b2b_gap", acc_cyc[1] - acc_cyc[0], 10);
    chk("b2b_accept_after_xfer", acc_cyc[1] - xfer_cyc[0], 1);

    // Reset during the 4th shift cycle aborts the word.
    in_valid = 1'b1;
    in_data  = 8'h7F;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_in_ready", in_ready, 1);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_out_data", out_data, 8'h00);
    seen_valid = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (out_valid === 1'b1) seen_valid++;
    end
    chk("abort_no_valid", seen_valid, 0);
    send("w02", 8'h02, 8'hFE, 1'b0, 1'b0, 0, 1'b0);

    send("wA7_noise", 8'hA7, 8'h59, 1'b0, 1'b0, 3, 1'b1);
    chk("final_busy", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
